// File: rtl/mult_sequencer.sv
// HI/LO multiply unit for the MIPS core: radix-2 shift-add MULT/MULTU with
// a fixed WIDTH+2 cycle latency, HI/LO hazard stall and MFHI/MFLO/MTHI/MTLO access.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_mfhi_req,
  input  logic             i_mflo_req,
  input  logic             i_mthi_we,
  input  logic             i_mtlo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_busy;
  logic               w_accept;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_result;

  assign w_busy   = (r_state == S_RUN) || (r_state == S_FIX);
  assign w_accept = i_start & ~w_busy;

  // Magnitudes are held unsigned, so the most-negative operand maps to 2^(WIDTH-1).
  assign w_mag_a  = (i_is_signed & i_op_a[WIDTH-1]) ? (~i_op_a + 1'b1) : i_op_a;
  assign w_mag_b  = (i_is_signed & i_op_b[WIDTH-1]) ? (~i_op_b + 1'b1) : i_op_b;
  assign w_result = r_neg ? (~r_acc + 1'b1) : r_acc;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = i_start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy    = w_busy;
    o_done    = (r_state == S_DONE);
    o_stall   = w_busy & (i_start | i_mfhi_req | i_mflo_req | i_mthi_we | i_mtlo_we);
    o_rd_data = '0;
    if (i_mfhi_req)      o_rd_data = r_hi;
    else if (i_mflo_req) o_rd_data = r_lo;
  end

  // Shift-add datapath; one multiplier bit per RUN cycle, no early exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH - 1);
      r_neg    <= i_is_signed & (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
    end else if (r_state == S_RUN) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
    end
  end

  // HI/LO: product commits at the end of FIX; moves only when idle and no start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      r_hi <= w_result[2*WIDTH-1:WIDTH];
      r_lo <= w_result[WIDTH-1:0];
    end else if (!w_busy && !i_start) begin
      if (i_mthi_we) r_hi <= i_wdata;
      if (i_mtlo_we) r_lo <= i_wdata;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Multi-cycle HI/LO multiply unit and its sequencer for the MIPS core.
- Accepts MULT/MULTU issue from the EX stage and runs a radix-2 shift-add multiply over WIDTH cycles.
- Commits the product to the HI/LO registers.
- Drives a pipeline stall for any HI/LO access that arrives while a multiply is in flight.
- Services MFHI/MFLO reads and MTHI/MTLO writes from the datapath.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  MULT/MULTU issue, sampled on the rising edge
is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
op_a  in  WIDTH  multiplicand (rs)
op_b  in  WIDTH  multiplier (rt)
mfhi_req  in  1  MFHI in EX this cycle
mflo_req  in  1  MFLO in EX this cycle
mthi_we  in  1  MTHI write request
mtlo_we  in  1  MTLO write request
wdata  in  WIDTH  MTHI/MTLO data
rd_data  out  WIDTH  MFHI/MFLO read data
stall  out  1  freeze IF/ID/EX
busy  out  1  multiply in progress
done  out  1  one-cycle pulse when HI/LO have been updated by a multiply
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=0, asynchronous, also mid-operation): state=IDLE; hi, lo, accumulator, counter and sign flag cleared to 0; busy=0, done=0, stall=0. Any in-flight multiply is discarded.
- States and transitions:
  - IDLE --start--> RUN.
  - RUN: counter runs WIDTH-1 down to 0; at 0 --> FIX.
  - FIX --> DONE, always.
  - DONE --start--> RUN; DONE --no start--> IDLE.
- Start capture (IDLE or DONE only):
  - Latch |op_a| and |op_b|; take magnitudes only when is_signed=1.
  - neg flag = is_signed & (op_a[MSB] ^ op_b[MSB]).
  - Accumulator cleared; counter = WIDTH-1.
  - Magnitude of the most-negative value (0x80000000) is 2^(WIDTH-1), held unsigned.
- RUN, each cycle: if multiplier LSB is 1, add the shifted multiplicand into the 2*WIDTH accumulator; shift the multiplier right by 1 and the multiplicand left by 1. No early termination; latency is fixed.
- FIX: result = neg ? two's-complement negation of accumulator : accumulator. hi/lo are written with result[2W-1:W] / result[W-1:0] at the end of the FIX cycle.
- DONE: done=1 for exactly one cycle; busy=0.
- Latency: start sampled at edge 0 -> hi/lo valid after edge WIDTH+1 -> done high during cycle WIDTH+2. With WIDTH=32: 34 cycles from start edge to the done cycle.
- busy=1 in RUN and FIX only.
- hi/lo hold their previous values throughout RUN; the accumulator is internal.
- stall is combinational: stall = busy & (start | mfhi_req | mflo_req | mthi_we | mtlo_we).
  - Requests are not consumed while stalled; the datapath holds them.
  - start while busy is ignored.
  - mthi_we/mtlo_we while busy: no write.
- MTHI/MTLO when not busy: hi<=wdata (mthi_we) and/or lo<=wdata (mtlo_we) at the edge.
  - If start is also sampled the same edge, start wins and the writes are dropped.
  - If DONE coincides with a write, the write applies after the multiply result, so the write's value persists.
- rd_data is combinational, valid only when stall=0:
  - mfhi_req ? hi : lo.
  - If both requests are high, HI has priority.
  - 0 when neither request is high.
- No other outputs change on stalled cycles.

Test Plan:
- Unsigned 3*5: MULTU op_a=3, op_b=5 -> busy for 33 cycles, done in cycle 34, hi=0x00000000, lo=0x0000000F.
- Signed corners:
  - MULT -2*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
  - MULT -1*-1 -> hi=0, lo=1.
- Unsigned max: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. The same operands with MULT -> hi=0, lo=1.
- Hazard: MFHI asserted cycle 2 after start -> stall=1 until DONE. rd_data = new hi in the DONE cycle with stall=0. A second start mid-RUN is ignored; hi/lo show only the first product.
- Moves: MTLO wdata=0xDEADBEEF in IDLE -> lo=0xDEADBEEF next cycle, stall=0. MTHI with start on the same edge -> hi unchanged by the move; the multiply proceeds.
- Reset mid-RUN: rst low at cycle 10 -> immediately state=IDLE, hi=lo=0, busy=stall=done=0. No done pulse after release. A new start then completes normally.
